sumador_secuencial_param: RTL and testbench

Parametrised multi-cycle adder that extends the 4-bit ripple adder to any operand width. Each cycle it processes one slice of ANCHO_BLOQUE bits, so a wide add takes ANCHO/ANCHO_BLOQUE cycles and needs only one narrow carry chain. It sits between a valid/ready producer and consumer, registers its operands and reports carry-out and signed overflow. It is the shared arithmetic unit for wide datapaths where area matters more than throughput.

---
 rtl/sumador_secuencial_param_pkg.sv | 29 ++
 rtl/sumador_secuencial_param_if.sv | 38 +++
 rtl/sumador_secuencial_param_bloque.sv | 29 ++
 rtl/sumador_secuencial_param.sv | 114 +++++++++++
 tb/tb_sumador_secuencial_param.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sumador_secuencial_param_pkg.sv
// Shared state type and elaboration helpers for the sequential slice adder.
// Subtract support is enabled by defining SUMADOR_RESTA_EN.
package sumador_pkg;

    typedef enum logic [1:0] {
        LIBRE   = 2'd0,
        SUMANDO = 2'd1,
        HECHO   = 2'd2
    } estado_e;

    function automatic int clog2(input int valor);
        int ancho;
        ancho = 0;
        while ((1 << ancho) < valor) begin
            ancho++;
        end
        return ancho;
    endfunction

    // A single-slice configuration still needs a one-bit counter.
    function automatic int ancho_contador(input int bloques);
        return (clog2(bloques) < 1) ? 1 : clog2(bloques);
    endfunction

    function automatic bit config_valida(input int ancho, input int ancho_bloque);
        return (ancho_bloque >= 1) && (ancho >= ancho_bloque) && ((ancho % ancho_bloque) == 0);
    endfunction

endpackage

// File: rtl/sumador_secuencial_param_if.sv
// Valid/ready operand and result bus of sumador_secuencial_param.
// The Modo signal only exists when SUMADOR_RESTA_EN is defined.
interface sumador_secuencial_param_if #(
    parameter int ANCHO = 32
);
    logic             Entrada_Valida;
    logic             Entrada_Lista;
    logic [ANCHO-1:0] X;
    logic [ANCHO-1:0] Y;
    logic             AcarreoEntrada;
`ifdef SUMADOR_RESTA_EN
    logic             Modo;
`endif
    logic             Salida_Valida;
    logic             Salida_Lista;
    logic [ANCHO-1:0] Salida;
    logic             CarriSalida;
    logic             Desborde;

    modport master (
        output Entrada_Valida, X, Y, AcarreoEntrada,
`ifdef SUMADOR_RESTA_EN
        output Modo,
`endif
        output Salida_Lista,
        input  Entrada_Lista, Salida_Valida, Salida, CarriSalida, Desborde
    );

    modport slave (
        input  Entrada_Valida, X, Y, AcarreoEntrada,
`ifdef SUMADOR_RESTA_EN
        input  Modo,
`endif
        input  Salida_Lista,
        output Entrada_Lista, Salida_Valida, Salida, CarriSalida, Desborde
    );

endinterface

// File: rtl/sumador_secuencial_param_bloque.sv
// Combinational ripple adder for one ANCHO_BLOQUE-bit slice; also exposes the
// carry entering its MSB so the caller can derive signed overflow.
module sumador_bloque #(
    parameter int ANCHO_BLOQUE = 4
) (
    input  logic [ANCHO_BLOQUE-1:0] a_i,
    input  logic [ANCHO_BLOQUE-1:0] b_i,
    input  logic                    c_i,
    output logic [ANCHO_BLOQUE-1:0] suma_o,
    output logic                    c_o,
    output logic                    c_msb_o
);

    logic [ANCHO_BLOQUE:0] acarreo;

    always_comb begin
        acarreo    = '0;
        suma_o     = '0;
        acarreo[0] = c_i;
        for (int i = 0; i < ANCHO_BLOQUE; i++) begin
            suma_o[i]    = a_i[i] ^ b_i[i] ^ acarreo[i];
            acarreo[i+1] = (a_i[i] & b_i[i]) | (acarreo[i] & (a_i[i] ^ b_i[i]));
        end
    end

    assign c_o     = acarreo[ANCHO_BLOQUE];
    assign c_msb_o = acarreo[ANCHO_BLOQUE-1];

endmodule

// File: rtl/sumador_secuencial_param.sv
// Multi-cycle adder: one ANCHO_BLOQUE-bit slice per cycle, ANCHO/ANCHO_BLOQUE cycles per add.
// Defining SUMADOR_RESTA_EN adds the Modo input for X - Y.
module sumador_secuencial_param
    import sumador_pkg::*;
#(
    parameter int ANCHO        = 32,
    parameter int ANCHO_BLOQUE = 4
) (
    input logic                        Reloj,
    input logic                        Reset_n,
    sumador_secuencial_param_if.slave  bus
);

    localparam int              B      = ANCHO / ANCHO_BLOQUE;
    localparam int              CW     = ancho_contador(B);
    localparam logic [CW-1:0]   ULTIMO = CW'(B - 1);

    if (!config_valida(ANCHO, ANCHO_BLOQUE)) begin : g_config_invalida
        $error("sumador_secuencial_param: ANCHO must be a non-zero multiple of ANCHO_BLOQUE");
    end

    estado_e          estado_q;
    logic [ANCHO-1:0] x_q;
    logic [ANCHO-1:0] y_q;
    logic             acarreo_q;
    logic [CW-1:0]    cuenta_q;
    logic [ANCHO-1:0] salida_q;
    logic             carri_q;
    logic             desborde_q;

    logic [ANCHO-1:0]        salida_d;
    logic [ANCHO-1:0]        y_ini;
    logic                    c_ini;
    logic [ANCHO_BLOQUE-1:0] suma_bloque;
    logic                    c_bloque;
    logic                    c_msb_bloque;

    // Subtraction is X + ~Y + 1, so only the latched operand and carry change.
`ifdef SUMADOR_RESTA_EN
    assign y_ini = bus.Modo ? ~bus.Y : bus.Y;
    assign c_ini = bus.Modo | bus.AcarreoEntrada;
`else
    assign y_ini = bus.Y;
    assign c_ini = bus.AcarreoEntrada;
`endif

    sumador_bloque #(
        .ANCHO_BLOQUE (ANCHO_BLOQUE)
    ) u_bloque (
        .a_i     (x_q[ANCHO_BLOQUE-1:0]),
        .b_i     (y_q[ANCHO_BLOQUE-1:0]),
        .c_i     (acarreo_q),
        .suma_o  (suma_bloque),
        .c_o     (c_bloque),
        .c_msb_o (c_msb_bloque)
    );

    // Each slice enters at the top, so after B shifts slice 0 sits at the LSB.
    if (ANCHO == ANCHO_BLOQUE) begin : g_un_bloque
        assign salida_d = suma_bloque;
    end else begin : g_varios_bloques
        assign salida_d = {suma_bloque, salida_q[ANCHO-1:ANCHO_BLOQUE]};
    end

    always_ff @(posedge Reloj or negedge Reset_n) begin
        if (!Reset_n) begin
            estado_q   <= LIBRE;
            x_q        <= '0;
            y_q        <= '0;
            acarreo_q  <= 1'b0;
            cuenta_q   <= '0;
            salida_q   <= '0;
            carri_q    <= 1'b0;
            desborde_q <= 1'b0;
        end else begin
            case (estado_q)
                LIBRE: begin
                    if (bus.Entrada_Valida) begin
                        x_q       <= bus.X;
                        y_q       <= y_ini;
                        acarreo_q <= c_ini;
                        cuenta_q  <= '0;
                        estado_q  <= SUMANDO;
                    end
                end
                SUMANDO: begin
                    salida_q  <= salida_d;
                    x_q       <= x_q >> ANCHO_BLOQUE;
                    y_q       <= y_q >> ANCHO_BLOQUE;
                    acarreo_q <= c_bloque;
                    cuenta_q  <= cuenta_q + 1'b1;
                    if (cuenta_q == ULTIMO) begin
                        carri_q    <= c_bloque;
                        desborde_q <= c_bloque ^ c_msb_bloque;
                        estado_q   <= HECHO;
                    end
                end
                HECHO: begin
                    if (bus.Salida_Lista) begin
                        estado_q <= LIBRE;
                    end
                end
                default: estado_q <= LIBRE;
            endcase
        end
    end

    assign bus.Entrada_Lista = (estado_q == LIBRE);
    assign bus.Salida_Valida = (estado_q == HECHO);
    assign bus.Salida        = salida_q;
    assign bus.CarriSalida   = carri_q;
    assign bus.Desborde      = desborde_q;

endmodule

// File: tb/tb_sumador_secuencial_param.sv
// Self-checking bench for sumador_secuencial_param: an 8-bit/4-bit instance and a
// 32-bit/8-bit instance, checked against an arithmetic reference model.
module tb_sumador_secuencial_param;

    logic Reloj = 1'b0;
    logic Reset_n;
    int   total = 0;
    int   bad   = 0;

    sumador_secuencial_param_if #(.ANCHO(8))  b8 ();
    sumador_secuencial_param_if #(.ANCHO(32)) b32 ();

    sumador_secuencial_param #(
        .ANCHO        (8),
        .ANCHO_BLOQUE (4)
    ) dut8 (
        .Reloj   (Reloj),
        .Reset_n (Reset_n),
        .bus     (b8.slave)
    );

    sumador_secuencial_param #(
        .ANCHO        (32),
        .ANCHO_BLOQUE (8)
    ) dut32 (
        .Reloj   (Reloj),
        .Reset_n (Reset_n),
        .bus     (b32.slave)
    );

    always #5 Reloj = ~Reloj;

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        bit         cin;
        bit         modo;
        logic [7:0] s;
        bit         c;
        bit         v;
    } vec_t;

    // Reference: true signed/unsigned arithmetic, then truncate to w bits.
    task automatic refModel(input longint unsigned x, input longint unsigned y, input bit cin,
                            input bit sub, input int w, output longint unsigned s,
                            output bit c, output bit v);
        longint unsigned m;
        longint unsigned completo;
        longint          sx;
        longint          sy;
        longint          verdadero;
        longint          maximo;
        m  = (64'd1 << w) - 64'd1;
        sx = x[w-1] ? longint'(x & m) - longint'(64'd1 << w) : longint'(x & m);
        sy = y[w-1] ? longint'(y & m) - longint'(64'd1 << w) : longint'(y & m);
        if (sub) begin
            completo  = (x & m) + (~y & m) + 64'd1;
            verdadero = sx - sy;
        end else begin
            completo  = (x & m) + (y & m) + longint'(cin);
            verdadero = sx + sy + longint'(cin);
        end
        s      = completo & m;
        c      = completo[w];
        maximo = longint'(64'd1 << (w - 1));
        v      = (verdadero > maximo - 1) || (verdadero < -maximo);
    endtask

    task automatic checkOutput(input string nombre, input longint unsigned actual,
                               input longint unsigned esperado);
        total++;
        if (actual !== esperado) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", nombre, actual, esperado);
        end
    endtask

    task automatic reportTimeout(input string nombre);
        total++;
        bad++;
        $display("[TB] FAIL %s: wait bound expired", nombre);
    endtask

    task automatic driveModo(input bit modo);
`ifdef SUMADOR_RESTA_EN
        b8.Modo  = modo;
        b32.Modo = modo;
`else
        if (modo) $display("[TB] note: subtract requested without SUMADOR_RESTA_EN");
`endif
    endtask

    // Called at a negedge; returns edges from acceptance to Salida_Valida and the result.
    task automatic applyStimulus(input bit ancho, input longint unsigned x, input longint unsigned y,
                                 input bit cin, input bit modo, output int lat,
                                 output longint unsigned s, output bit c, output bit v);
        int espera;
        espera = 0;
        lat    = -1;
        while (!(ancho ? b32.Entrada_Lista : b8.Entrada_Lista) && espera < 50) begin
            @(negedge Reloj);
            espera++;
        end
        if (espera >= 50) reportTimeout("ready wait");
        driveModo(modo);
        if (ancho) begin
            b32.X = x[31:0];
            b32.Y = y[31:0];
            b32.AcarreoEntrada = cin;
            b32.Entrada_Valida = 1'b1;
        end else begin
            b8.X = x[7:0];
            b8.Y = y[7:0];
            b8.AcarreoEntrada = cin;
            b8.Entrada_Valida = 1'b1;
        end
        @(negedge Reloj);
        b8.Entrada_Valida  = 1'b0;
        b32.Entrada_Valida = 1'b0;
        lat = 0;
        while (!(ancho ? b32.Salida_Valida : b8.Salida_Valida) && lat < 50) begin
            @(negedge Reloj);
            lat++;
        end
        if (lat >= 50) reportTimeout("result wait");
        s = ancho ? longint'(b32.Salida) : longint'(b8.Salida);
        c = ancho ? b32.CarriSalida : b8.CarriSalida;
        v = ancho ? b32.Desborde : b8.Desborde;
    endtask

    task automatic releaseOutput(input bit ancho);
        if (ancho) b32.Salida_Lista = 1'b1;
        else       b8.Salida_Lista  = 1'b1;
        @(negedge Reloj);
        b8.Salida_Lista  = 1'b0;
        b32.Salida_Lista = 1'b0;
        checkOutput("release valid", ancho ? b32.Salida_Valida : b8.Salida_Valida, 0);
        checkOutput("release ready", ancho ? b32.Entrada_Lista : b8.Entrada_Lista, 1);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t            tabla[$];
        int              lat;
        int              vistos;
        longint unsigned s;
        longint unsigned es;
        bit              c;
        bit              v;
        bit              ec;
        bit              ev;
        bit              modo;
        longint unsigned rx;
        longint unsigned ry;
        bit              rc;

        b8.Entrada_Valida  = 1'b0; b8.X  = '0; b8.Y  = '0; b8.AcarreoEntrada  = 1'b0; b8.Salida_Lista  = 1'b0;
        b32.Entrada_Valida = 1'b0; b32.X = '0; b32.Y = '0; b32.AcarreoEntrada = 1'b0; b32.Salida_Lista = 1'b0;
        driveModo(1'b0);
        Reset_n = 1'b0;
        @(negedge Reloj);
        @(negedge Reloj);
        checkOutput("reset ready8", b8.Entrada_Lista, 1);
        checkOutput("reset valid8", b8.Salida_Valida, 0);
        checkOutput("reset sum8", b8.Salida, 0);
        checkOutput("reset carry8", b8.CarriSalida, 0);
        checkOutput("reset ready32", b32.Entrada_Lista, 1);
        checkOutput("reset valid32", b32.Salida_Valida, 0);
        Reset_n = 1'b1;
        @(negedge Reloj);

        tabla.push_back('{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0});
        tabla.push_back('{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0});
        tabla.push_back('{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1});
        tabla.push_back('{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1});
        tabla.push_back('{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0});
        tabla.push_back('{8'h40, 8'h3F, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1});
`ifdef SUMADOR_RESTA_EN
        tabla.push_back('{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0});
        tabla.push_back('{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1});
        tabla.push_back('{8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0});
`endif
        for (int i = 0; i < tabla.size(); i++) begin
            applyStimulus(1'b0, tabla[i].x, tabla[i].y, tabla[i].cin, tabla[i].modo, lat, s, c, v);
            checkOutput($sformatf("vec%0d sum", i), s, tabla[i].s);
            checkOutput($sformatf("vec%0d carry", i), c, tabla[i].c);
            checkOutput($sformatf("vec%0d ovf", i), v, tabla[i].v);
            checkOutput($sformatf("vec%0d latency", i), lat, 2);
            releaseOutput(1'b0);
        end

        // Backpressure: result held, new request ignored while in HECHO.
        applyStimulus(1'b0, 8'h21, 8'h13, 1'b0, 1'b0, lat, s, c, v);
        checkOutput("bp sum", s, 8'h34);
        b8.X = 8'h11;
        b8.Y = 8'h11;
        b8.Entrada_Valida = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge Reloj);
            checkOutput("bp hold sum", b8.Salida, 8'h34);
            checkOutput("bp hold ready", b8.Entrada_Lista, 0);
            checkOutput("bp hold valid", b8.Salida_Valida, 1);
        end
        b8.Entrada_Valida = 1'b0;
        releaseOutput(1'b0);
        checkOutput("bp sum in idle", b8.Salida, 8'h34);

        // Reset during SUMANDO discards the operation.
        b8.X = 8'h55;
        b8.Y = 8'h22;
        b8.AcarreoEntrada = 1'b0;
        b8.Entrada_Valida = 1'b1;
        @(negedge Reloj);
        b8.Entrada_Valida = 1'b0;
        Reset_n = 1'b0;
        #1;
        checkOutput("midreset sum", b8.Salida, 0);
        checkOutput("midreset carry", b8.CarriSalida, 0);
        checkOutput("midreset ovf", b8.Desborde, 0);
        checkOutput("midreset valid", b8.Salida_Valida, 0);
        checkOutput("midreset ready", b8.Entrada_Lista, 1);
        @(negedge Reloj);
        Reset_n = 1'b1;
        vistos = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge Reloj);
            if (b8.Salida_Valida) vistos++;
        end
        checkOutput("midreset no result", vistos, 0);
        applyStimulus(1'b0, 8'h03, 8'h04, 1'b0, 1'b0, lat, s, c, v);
        checkOutput("after reset sum", s, 8'h07);
        releaseOutput(1'b0);

        for (int i = 0; i < 25; i++) begin
            rx = longint'($urandom_range(0, 255));
            ry = longint'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
`ifdef SUMADOR_RESTA_EN
            modo = 1'($urandom_range(0, 1));
`else
            modo = 1'b0;
`endif
            refModel(rx, ry, rc, modo, 8, es, ec, ev);
            applyStimulus(1'b0, rx, ry, rc, modo, lat, s, c, v);
            checkOutput($sformatf("rnd8 %0d sum", i), s, es);
            checkOutput($sformatf("rnd8 %0d carry", i), c, ec);
            checkOutput($sformatf("rnd8 %0d ovf", i), v, ev);
            releaseOutput(1'b0);
        end

        driveModo(1'b0);
        applyStimulus(1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, lat, s, c, v);
        checkOutput("wide sum", s, 0);
        checkOutput("wide carry", c, 1);
        checkOutput("wide ovf", v, 0);
        checkOutput("wide latency", lat, 4);
        releaseOutput(1'b1);

        for (int i = 0; i < 15; i++) begin
            rx = longint'($urandom());
            ry = longint'($urandom());
            rc = 1'($urandom_range(0, 1));
`ifdef SUMADOR_RESTA_EN
            modo = 1'($urandom_range(0, 1));
`else
            modo = 1'b0;
`endif
            refModel(rx, ry, rc, modo, 32, es, ec, ev);
            applyStimulus(1'b1, rx, ry, rc, modo, lat, s, c, v);
            checkOutput($sformatf("rnd32 %0d sum", i), s, es);
            checkOutput($sformatf("rnd32 %0d carry", i), c, ec);
            checkOutput($sformatf("rnd32 %0d ovf", i), v, ev);
            checkOutput($sformatf("rnd32 %0d latency", i), lat, 4);
            releaseOutput(1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
